// File: rtl/uart_cmd_parser.sv
// Host command decoder: "l"/"a" + 4 BCD digits + CR commit time/alarm, "@" toggles alarm enable.
// All pulses, digit outputs and echo are registered one cycle after the rx strobe; no backpressure.
module uart_cmd_parser #(
  parameter int         TIMEOUT = 240000,
  parameter bit         ECHO    = 1'b1,
  parameter logic [7:0] CR_CHAR = 8'h0d
) (
  input  logic       clk12m,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic       alarm_tgl,
  output logic [3:0] mtens,
  output logic [3:0] mones,
  output logic [3:0] stens,
  output logic [3:0] sones,
  output logic       cmd_err,
  output logic [7:0] tx_data,
  output logic       tx_data_rdy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, DIG, WAIT_CR} state_t;

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic            kind, kind_nxt;   // 1 = alarm command
  logic [3:0][3:0] shadow, shadow_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            commit;
  logic            ld_time_nxt, ld_alarm_nxt, alarm_tgl_nxt, cmd_err_nxt;

  logic is_l, is_a, is_dig, dig_ok;

  assign is_l   = (rx_data == 8'h6c) || (rx_data == 8'h4c);
  assign is_a   = (rx_data == 8'h61) || (rx_data == 8'h41);
  assign is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // Tens positions (even index) only allow 0-5
  assign dig_ok = is_dig && (rx_data[3:0] <= (idx[0] ? 4'd9 : 4'd5));

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    kind_nxt      = kind;
    shadow_nxt    = shadow;
    cnt_nxt       = cnt;
    commit        = 1'b0;
    ld_time_nxt   = 1'b0;
    ld_alarm_nxt  = 1'b0;
    alarm_tgl_nxt = 1'b0;
    cmd_err_nxt   = 1'b0;

    if (rx_data_rdy) begin
      cnt_nxt = '0;
      if (is_l || is_a) begin
        state_nxt = DIG;
        idx_nxt   = 2'd0;
        kind_nxt  = is_a;
      end else begin
        case (state)
          IDLE: begin
            if (rx_data == 8'h40) alarm_tgl_nxt = 1'b1;
          end
          DIG: begin
            if (dig_ok) begin
              shadow_nxt[idx] = rx_data[3:0];
              idx_nxt         = idx + 2'd1;
              if (idx == 2'd3) state_nxt = WAIT_CR;
            end else begin
              cmd_err_nxt = 1'b1;
              state_nxt   = IDLE;
            end
          end
          default: begin
            if (rx_data == CR_CHAR) begin
              commit       = 1'b1;
              ld_time_nxt  = ~kind;
              ld_alarm_nxt = kind;
            end else begin
              cmd_err_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end
        endcase
      end
    end else if (state != IDLE && TIMEOUT != 0) begin
      if (cnt == CW'(TIMEOUT - 1)) begin
        cmd_err_nxt = 1'b1;
        state_nxt   = IDLE;
        cnt_nxt     = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 2'd0;
      kind        <= 1'b0;
      shadow      <= '0;
      cnt         <= '0;
      ld_time     <= 1'b0;
      ld_alarm    <= 1'b0;
      alarm_tgl   <= 1'b0;
      cmd_err     <= 1'b0;
      mtens       <= 4'd0;
      mones       <= 4'd0;
      stens       <= 4'd0;
      sones       <= 4'd0;
      tx_data     <= 8'h00;
      tx_data_rdy <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      kind        <= kind_nxt;
      shadow      <= shadow_nxt;
      cnt         <= cnt_nxt;
      ld_time     <= ld_time_nxt;
      ld_alarm    <= ld_alarm_nxt;
      alarm_tgl   <= alarm_tgl_nxt;
      cmd_err     <= cmd_err_nxt;
      if (commit) begin
        mtens <= shadow[0];
        mones <= shadow[1];
        stens <= shadow[2];
        sones <= shadow[3];
      end
      tx_data_rdy <= ECHO && rx_data_rdy;
      if (ECHO && rx_data_rdy) tx_data <= rx_data;
    end
  end

endmodule
